max_scale_tracker: RTL

//  Downstream of the 64-input max comparator tree. Folds the per-row maxima of one channel group into a group max.

---
 rtl/tender_quant_pkg.sv | 20 ++
 rtl/lead_one_enc.sv | 24 ++
 rtl/max_scale_tracker.sv | 116 +++++++++++
 3 files changed

// File: rtl/tender_quant_pkg.sv
// Shared types and helpers for the quantization scale path.
//   max_trk_state_t : FSM states of max_scale_tracker (ACCUM, CALC, OUT)
//   QMAG_LIMIT      : largest signed magnitude for the default 8-bit quant target
//   clog2           : ceiling log2 used for index widths
package tender_quant_pkg;

    typedef enum logic [1:0] {ACCUM, CALC, OUT} max_trk_state_t;

    localparam int QUANT_BITS_DFLT = 8;
    localparam int QMAG_LIMIT      = 2**(QUANT_BITS_DFLT-1) - 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Combinational leading-one (priority) encoder.
//   din  : input word
//   msb  : index of the highest set bit (0 when din is zero)
//   zero : din is all zeros
module lead_one_enc
    import tender_quant_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [IDX_W-1:0]      msb,
    output logic                  zero
);

    always_comb begin
        msb  = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < DATA_WIDTH; i++)
            if (din[i]) msb = IDX_W'(i);
        zero = (din == '0);
    end

endmodule

// File: rtl/max_scale_tracker.sv
// Folds per-row maxima of one channel group into a group max, derives the
// right-shift that fits the max into a signed QUANT_BITS integer, and hands
// {scale_max, scale_shift} to the quantizer over valid/ready.
// Optional: define MAX_SCALE_GRPCNT_EN to add the grp_cnt output.
// Ports:
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : row handshake; in_max row max, in_last closes group
//   scale_valid/ready     : result handshake; scale_max, scale_shift result
//   grp_cnt (optional)    : count of delivered results, wraps at 16 bits
//   row_cnt               : rows folded into the current or last group
module max_scale_tracker
    import tender_quant_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int QUANT_BITS = 8,
    parameter int MAX_ROWS   = 64,
    parameter int SHIFT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_max,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  scale_valid,
    input  logic                  scale_ready,
    output logic [DATA_WIDTH-1:0] scale_max,
    output logic [SHIFT_W-1:0]    scale_shift,
`ifdef MAX_SCALE_GRPCNT_EN
    output logic [15:0]           grp_cnt,
`endif
    output logic [6:0]            row_cnt
);

    localparam int IDX_W = clog2(DATA_WIDTH);
    // A value whose bit length exceeds this needs shifting to fit.
    localparam int MAG_BITS = QUANT_BITS - 1;

    max_trk_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] acc_q;
    logic                  accept;
    logic                  close_grp;
    logic [IDX_W-1:0]      lead_msb;
    logic                  lead_zero;
    logic [SHIFT_W-1:0]    calc_shift;

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid & in_ready;
    // The row that brings the count to MAX_ROWS closes the group regardless of in_last.
    assign close_grp = in_last | (row_cnt == 7'(MAX_ROWS - 1));

    lead_one_enc #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_lead (
        .din  (acc_q),
        .msb  (lead_msb),
        .zero (lead_zero)
    );

    always_comb begin
        calc_shift = '0;
        if (!lead_zero && (int'(lead_msb) + 1 > MAG_BITS))
            calc_shift = SHIFT_W'(int'(lead_msb) + 1 - MAG_BITS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (accept && close_grp) state_d = CALC;
            CALC:    state_d = OUT;
            OUT:     if (scale_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            row_cnt     <= '0;
            scale_valid <= 1'b0;
            scale_max   <= '0;
            scale_shift <= '0;
        end else begin
            unique case (state_q)
                ACCUM: if (accept) begin
                    // First row loads directly; ties keep the stored value.
                    acc_q   <= (row_cnt == '0 || in_max > acc_q) ? in_max : acc_q;
                    row_cnt <= row_cnt + 7'd1;
                end
                CALC: begin
                    scale_max   <= acc_q;
                    scale_shift <= calc_shift;
                    scale_valid <= 1'b1;
                end
                OUT: if (scale_ready) begin
                    scale_valid <= 1'b0;
                    row_cnt     <= '0;
                    acc_q       <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef MAX_SCALE_GRPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            grp_cnt <= '0;
        else if (scale_valid && scale_ready) grp_cnt <= grp_cnt + 16'd1;
    end
`endif

endmodule
